// File: rtl/pipeline_controller_if.sv
// Hazard/redirect bundle between the pipeline stages and the stall/flush sequencer.
// With RAFI_PIPELINE_PERF_COUNTER_EN defined it also carries stallCycles and flushCount.
interface pipeline_controller_if;
    logic        idValid;
    logic        idReadRs1;
    logic        idReadRs2;
    logic [4:0]  idRs1;
    logic [4:0]  idRs2;
    logic        exLoadValid;
    logic [4:0]  exLoadRd;
    logic        exBusy;
    logic        branchMiss;
    logic [31:0] branchTarget;
    logic        trapValid;
    logic [31:0] trapTarget;
    logic        memDrained;
    logic        ifStall;
    logic        idStall;
    logic        rrStall;
    logic        exStall;
    logic        rrBubble;
    logic        flush;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        busy;
`ifdef RAFI_PIPELINE_PERF_COUNTER_EN
    logic [31:0] stallCycles;
    logic [31:0] flushCount;
`endif

    // Pipeline side: reports hazards and events, consumes stall/flush controls.
    modport master (
`ifdef RAFI_PIPELINE_PERF_COUNTER_EN
        input  stallCycles, flushCount,
`endif
        output idValid, idReadRs1, idReadRs2, idRs1, idRs2,
        output exLoadValid, exLoadRd, exBusy,
        output branchMiss, branchTarget, trapValid, trapTarget, memDrained,
        input  ifStall, idStall, rrStall, exStall, rrBubble,
        input  flush, redirectValid, redirectPc, busy
    );

    // Sequencer side.
    modport slave (
`ifdef RAFI_PIPELINE_PERF_COUNTER_EN
        output stallCycles, flushCount,
`endif
        input  idValid, idReadRs1, idReadRs2, idRs1, idRs2,
        input  exLoadValid, exLoadRd, exBusy,
        input  branchMiss, branchTarget, trapValid, trapTarget, memDrained,
        output ifStall, idStall, rrStall, exStall, rrBubble,
        output flush, redirectValid, redirectPc, busy
    );
endinterface

// File: rtl/pipeline_controller.sv
// Stall/flush sequencer: load-use and multicycle stalls, branch redirect, trap drain.
// Defining RAFI_PIPELINE_PERF_COUNTER_EN adds the stallCycles/flushCount counters.
module pipeline_controller (
    input logic                  clk,
    input logic                  rst,
    pipeline_controller_if.slave ctrl
);
    typedef enum logic [1:0] {StNormal, StDrain, StRedirect} state_e;

    state_e      state_q, state_d;
    logic        flush_q, flush_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] trap_target_q, trap_target_d;

    logic load_use;
    logic if_stall, id_stall, rr_stall, ex_stall, rr_bubble;

    assign load_use = ctrl.idValid && ctrl.exLoadValid && (ctrl.exLoadRd != 5'd0) &&
                      ((ctrl.idReadRs1 && (ctrl.idRs1 == ctrl.exLoadRd)) ||
                       (ctrl.idReadRs2 && (ctrl.idRs2 == ctrl.exLoadRd)));

    // The drain freeze holds even in its flush cycle so the trap window is stalled end to end.
    always_comb begin
        if_stall  = 1'b0;
        id_stall  = 1'b0;
        rr_stall  = 1'b0;
        ex_stall  = 1'b0;
        rr_bubble = 1'b0;
        case (state_q)
            StDrain: begin
                if_stall = 1'b1;
                id_stall = 1'b1;
                rr_stall = 1'b1;
                ex_stall = 1'b1;
            end
            StNormal: begin
                if (!flush_q) begin
                    if (ctrl.exBusy) begin
                        if_stall = 1'b1;
                        id_stall = 1'b1;
                        rr_stall = 1'b1;
                        ex_stall = 1'b1;
                    end else if (load_use) begin
                        if_stall  = 1'b1;
                        id_stall  = 1'b1;
                        rr_bubble = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        flush_d          = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        trap_target_d    = trap_target_q;
        case (state_q)
            StNormal: begin
                if (ctrl.trapValid) begin
                    trap_target_d = ctrl.trapTarget;
                    flush_d       = 1'b1;
                    state_d       = StDrain;
                end else if (ctrl.branchMiss) begin
                    flush_d          = 1'b1;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = ctrl.branchTarget;
                end
            end
            StDrain: begin
                if (ctrl.memDrained) begin
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = trap_target_q;
                    state_d          = StRedirect;
                end
            end
            StRedirect: state_d = StNormal;
            default:    state_d = StNormal;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StNormal;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            trap_target_q    <= 32'd0;
        end else begin
            state_q          <= state_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            trap_target_q    <= trap_target_d;
        end
    end

    assign ctrl.ifStall       = if_stall;
    assign ctrl.idStall       = id_stall;
    assign ctrl.rrStall       = rr_stall;
    assign ctrl.exStall       = ex_stall;
    assign ctrl.rrBubble      = rr_bubble;
    assign ctrl.flush         = flush_q;
    assign ctrl.redirectValid = redirect_valid_q;
    assign ctrl.redirectPc    = redirect_pc_q;
    assign ctrl.busy          = (state_q != StNormal);

`ifdef RAFI_PIPELINE_PERF_COUNTER_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 32'd0;
        end else begin
            if (if_stall) stall_cycles_q <= stall_cycles_q + 32'd1;
            if (flush_q)  flush_count_q  <= flush_count_q + 32'd1;
        end
    end

    assign ctrl.stallCycles = stall_cycles_q;
    assign ctrl.flushCount  = flush_count_q;
`endif
endmodule

// File: tb/tb_pipeline_controller.sv
// Bench for pipeline_controller: directed stimulus, cycle model checked every negedge,
// plus literal expectations for the key scenarios.
module tb_pipeline_controller;
    logic clk = 1'b0;
    logic rst;

    pipeline_controller_if bus ();

    pipeline_controller dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: drain_age counts cycles spent waiting for the store buffer (0 = not draining).
    int          drain_age   = 0;
    bit          in_redirect = 1'b0;
    bit          m_flush     = 1'b0;
    bit          m_rv        = 1'b0;
    logic [31:0] m_pc        = 32'd0;
    logic [31:0] m_trap_pc   = 32'd0;
    logic [31:0] m_stall_cnt = 32'd0;
    logic [31:0] m_flush_cnt = 32'd0;

    always @(negedge clk) begin
        bit lu, e_if, e_id, e_rr, e_ex, e_bub;
        lu = bus.idValid && bus.exLoadValid && (bus.exLoadRd != 5'd0) &&
             ((bus.idReadRs1 && bus.idRs1 == bus.exLoadRd) ||
              (bus.idReadRs2 && bus.idRs2 == bus.exLoadRd));
        e_if = 0; e_id = 0; e_rr = 0; e_ex = 0; e_bub = 0;
        if (drain_age > 0) begin
            e_if = 1; e_id = 1; e_rr = 1; e_ex = 1;
        end else if (!in_redirect && !m_flush) begin
            if (bus.exBusy) begin
                e_if = 1; e_id = 1; e_rr = 1; e_ex = 1;
            end else if (lu) begin
                e_if = 1; e_id = 1; e_bub = 1;
            end
        end
        if (check_en) begin
            chk("m_ifStall",  {31'd0, bus.ifStall},       {31'd0, e_if});
            chk("m_idStall",  {31'd0, bus.idStall},       {31'd0, e_id});
            chk("m_rrStall",  {31'd0, bus.rrStall},       {31'd0, e_rr});
            chk("m_exStall",  {31'd0, bus.exStall},       {31'd0, e_ex});
            chk("m_rrBubble", {31'd0, bus.rrBubble},      {31'd0, e_bub});
            chk("m_flush",    {31'd0, bus.flush},         {31'd0, m_flush});
            chk("m_redirV",   {31'd0, bus.redirectValid}, {31'd0, m_rv});
            chk("m_redirPc",  bus.redirectPc,             m_pc);
            chk("m_busy",     {31'd0, bus.busy},
                {31'd0, (drain_age > 0) || in_redirect});
`ifdef RAFI_PIPELINE_PERF_COUNTER_EN
            chk("m_stallCycles", bus.stallCycles, m_stall_cnt);
            chk("m_flushCount",  bus.flushCount,  m_flush_cnt);
`endif
        end
        if (rst) begin
            drain_age = 0; in_redirect = 0; m_flush = 0; m_rv = 0;
            m_pc = 0; m_trap_pc = 0; m_stall_cnt = 0; m_flush_cnt = 0;
        end else begin
            m_stall_cnt = m_stall_cnt + {31'd0, e_if};
            m_flush_cnt = m_flush_cnt + {31'd0, m_flush};
            if (drain_age > 0) begin
                m_flush = 0;
                if (bus.memDrained) begin
                    drain_age = 0; in_redirect = 1; m_rv = 1; m_pc = m_trap_pc;
                end else begin
                    drain_age++;
                end
            end else if (in_redirect) begin
                in_redirect = 0; m_rv = 0;
            end else if (bus.trapValid) begin
                m_trap_pc = bus.trapTarget; drain_age = 1; m_flush = 1; m_rv = 0;
            end else if (bus.branchMiss) begin
                m_flush = 1; m_rv = 1; m_pc = bus.branchTarget;
            end else begin
                m_flush = 0; m_rv = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.idValid = 0; bus.idReadRs1 = 0; bus.idReadRs2 = 0; bus.idRs1 = 0; bus.idRs2 = 0;
        bus.exLoadValid = 0; bus.exLoadRd = 0; bus.exBusy = 0;
        bus.branchMiss = 0; bus.branchTarget = 0; bus.trapValid = 0; bus.trapTarget = 0;
        bus.memDrained = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef RAFI_PIPELINE_PERF_COUNTER_EN
        logic [31:0] base_stall, base_flush;
`endif
        rst = 1'b1;
        idle();
        tick();
        check_en = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("reset_flush", {31'd0, bus.flush},         32'd0);
        chk("reset_rv",    {31'd0, bus.redirectValid}, 32'd0);
        chk("reset_pc",    bus.redirectPc,             32'd0);
        chk("reset_busy",  {31'd0, bus.busy},          32'd0);

        // Load-use on rs2, then the same with x0 as load destination.
        tick();
        bus.idValid = 1; bus.exLoadValid = 1; bus.exLoadRd = 5; bus.idReadRs2 = 1; bus.idRs2 = 5;
        #1;
        chk("lu_ifStall",  {31'd0, bus.ifStall},  32'd1);
        chk("lu_idStall",  {31'd0, bus.idStall},  32'd1);
        chk("lu_rrBubble", {31'd0, bus.rrBubble}, 32'd1);
        chk("lu_rrStall",  {31'd0, bus.rrStall},  32'd0);
        chk("lu_exStall",  {31'd0, bus.exStall},  32'd0);
        tick();
        bus.exLoadRd = 0; bus.idRs2 = 0;
        #1;
        chk("lu_x0_ifStall",  {31'd0, bus.ifStall},  32'd0);
        chk("lu_x0_rrBubble", {31'd0, bus.rrBubble}, 32'd0);
        tick();
        bus.exLoadRd = 7; bus.idReadRs2 = 0; bus.idReadRs1 = 1; bus.idRs1 = 7;
        #1;
        chk("lu_rs1_ifStall", {31'd0, bus.ifStall}, 32'd1);

        // exBusy over a live load-use hazard for three cycles.
        tick();
        bus.exBusy = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("busy_exStall",  {31'd0, bus.exStall},  32'd1);
            chk("busy_rrBubble", {31'd0, bus.rrBubble}, 32'd0);
            tick();
        end
        bus.exBusy = 0;
        #1;
        chk("busy_drop_exStall", {31'd0, bus.exStall}, 32'd0);
        chk("busy_drop_rrStall", {31'd0, bus.rrStall}, 32'd0);

        // Branch mispredict; hazard in the flush cycle must be suppressed.
        tick();
        idle();
        bus.branchMiss = 1; bus.branchTarget = 32'h8000_0100;
        tick();
        bus.branchMiss = 0;
        bus.idValid = 1; bus.exLoadValid = 1; bus.exLoadRd = 3; bus.idReadRs1 = 1; bus.idRs1 = 3;
        #1;
        chk("br_flush",   {31'd0, bus.flush},         32'd1);
        chk("br_rv",      {31'd0, bus.redirectValid}, 32'd1);
        chk("br_pc",      bus.redirectPc,             32'h8000_0100);
        chk("br_busy",    {31'd0, bus.busy},          32'd0);
        chk("br_ifStall", {31'd0, bus.ifStall},       32'd0);
        tick();
        idle();
        #1;
        chk("br_flush_off", {31'd0, bus.flush},         32'd0);
        chk("br_rv_off",    {31'd0, bus.redirectValid}, 32'd0);
        chk("br_pc_hold",   bus.redirectPc,             32'h8000_0100);

        // Back-to-back mispredicts: second one arrives during the first flush.
        tick();
        bus.branchMiss = 1; bus.branchTarget = 32'h8000_0200;
        tick();
        bus.branchTarget = 32'h8000_0300;
        #1;
        chk("b2b_pc1", bus.redirectPc, 32'h8000_0200);
        tick();
        idle();
        #1;
        chk("b2b_flush2", {31'd0, bus.flush}, 32'd1);
        chk("b2b_pc2",    bus.redirectPc,     32'h8000_0300);
        tick();

        // Trap with simultaneous mispredict; memDrained rises four cycles into the drain.
        tick();
        bus.trapValid = 1; bus.branchMiss = 1;
        bus.trapTarget = 32'h8000_0004; bus.branchTarget = 32'hDEAD_BEEF;
`ifdef RAFI_PIPELINE_PERF_COUNTER_EN
        #1;
        base_stall = bus.stallCycles;
        base_flush = bus.flushCount;
`endif
        tick();
        bus.trapValid = 0; bus.branchMiss = 0;
        #1;
        chk("tr_flush_first", {31'd0, bus.flush},         32'd1);
        chk("tr_stall_first", {31'd0, bus.ifStall},       32'd1);
        chk("tr_busy",        {31'd0, bus.busy},          32'd1);
        chk("tr_no_branch",   {31'd0, bus.redirectValid}, 32'd0);
        for (int c = 22; c <= 24; c++) begin
            tick();
            bus.trapValid  = (c == 23);
            bus.branchMiss = (c == 23);
            bus.trapTarget = 32'h0BAD_0000;
            #1;
            chk("tr_flush_off", {31'd0, bus.flush},         32'd0);
            chk("tr_exStall",   {31'd0, bus.exStall},       32'd1);
            chk("tr_rv_off",    {31'd0, bus.redirectValid}, 32'd0);
        end
        tick();
        bus.trapValid = 0; bus.branchMiss = 0; bus.memDrained = 1;
        #1;
        chk("tr_stall_last", {31'd0, bus.rrStall}, 32'd1);
        tick();
        bus.memDrained = 0;
        #1;
        chk("tr_rv",       {31'd0, bus.redirectValid}, 32'd1);
        chk("tr_pc",       bus.redirectPc,             32'h8000_0004);
        chk("tr_unstall",  {31'd0, bus.ifStall},       32'd0);
        chk("tr_busy_red", {31'd0, bus.busy},          32'd1);
        tick();
        #1;
        chk("tr_normal",  {31'd0, bus.busy},          32'd0);
        chk("tr_rv_done", {31'd0, bus.redirectValid}, 32'd0);
`ifdef RAFI_PIPELINE_PERF_COUNTER_EN
        chk("perf_stall5", bus.stallCycles - base_stall, 32'd5);
        chk("perf_flush1", bus.flushCount - base_flush,  32'd1);
`endif

        // Minimum trap-to-redirect latency.
        tick();
        bus.trapValid = 1; bus.trapTarget = 32'h0000_0100; bus.memDrained = 1;
        tick();
        bus.trapValid = 0;
        tick();
        #1;
        chk("trmin_rv", {31'd0, bus.redirectValid}, 32'd1);
        chk("trmin_pc", bus.redirectPc,             32'h0000_0100);
        tick();
        idle();

        // Reset in the second drain cycle, then a normal mispredict.
        tick();
        bus.trapValid = 1; bus.trapTarget = 32'h0000_0200;
        tick();
        bus.trapValid = 0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_busy",  {31'd0, bus.busy},          32'd0);
        chk("rst_flush", {31'd0, bus.flush},         32'd0);
        chk("rst_rv",    {31'd0, bus.redirectValid}, 32'd0);
        chk("rst_pc",    bus.redirectPc,             32'd0);
        chk("rst_stall", {31'd0, bus.exStall},       32'd0);
        tick();
        bus.branchMiss = 1; bus.branchTarget = 32'h0000_0300;
        tick();
        bus.branchMiss = 0;
        #1;
        chk("rst_br_rv", {31'd0, bus.redirectValid}, 32'd1);
        chk("rst_br_pc", bus.redirectPc,             32'h0000_0300);
        tick();

`ifdef RAFI_PIPELINE_PERF_COUNTER_EN
        // Counter wrap from all-ones after one stall cycle.
        tick();
        dut.stall_cycles_q = 32'hFFFF_FFFF;
        m_stall_cnt = 32'hFFFF_FFFF;
        tick();
        bus.exBusy = 1;
        tick();
        bus.exBusy = 0;
        #1;
        chk("perf_wrap", bus.stallCycles, 32'd0);
`endif

        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
